hare_scheduler: RTL and testbench

HARE_SCHEDULER -- requirements
Module: hare_scheduler

---
 rtl/hare_scheduler.sv | 171 +++++++++++++++++
 tb/tb_hare_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hare_scheduler.sv
// hare_scheduler: round-robin front end that feeds one operation at a time to the hare datapath.
// Define HARE_SCHED_REBIRTH_EN to enable periodic and external datapath rebirth.
module hare_scheduler #(
    parameter int N_REQ          = 4,
    parameter int REBIRTH_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     grant,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_data,
    output logic [2:0]           resp_id,
    input  logic                 rebirth_req,
    output logic                 rebirth_done,
    output logic                 rebirth_err,
    output logic [31:0]          hc_data_in,
    output logic                 hc_trigger_rebirth,
    input  logic [31:0]          hc_data_out,
    input  logic                 hc_rebirth_active
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_RESP    = 3'd3
`ifdef HARE_SCHED_REBIRTH_EN
        ,
        S_REBIRTH   = 3'd4,
        S_REB_CHECK = 3'd5
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   op_q, op_d;
    logic [2:0]    id_q, id_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic [PW-1:0] sel, idx;
    logic          any_req;

    // Walk the requesters from the far end back towards rr_ptr so the
    // closest active requester at or after the pointer is left in sel.
    always_comb begin
        sel     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_valid[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

`ifdef HARE_SCHED_REBIRTH_EN
    logic [7:0] op_cnt_q, op_cnt_d;
    logic       pending_q, pending_d;
    logic       err_q, err_d;
    logic       rebirth_due;

    assign rebirth_due = pending_q | (op_cnt_q == 8'(REBIRTH_PERIOD));
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
        grant       = '0;
        case (state_q)
            S_IDLE: begin
`ifdef HARE_SCHED_REBIRTH_EN
                if (rebirth_due) begin
                    state_d = S_REBIRTH;
                end else
`endif
                if (any_req) begin
                    grant[sel] = ~rst;
                    op_d       = req_data[32*int'(sel) +: 32];
                    id_d       = 3'(sel);
                    rr_ptr_d   = PW'((int'(sel) + 1) % N_REQ);
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: begin
                resp_data_d = hc_data_out;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
`ifdef HARE_SCHED_REBIRTH_EN
            S_REBIRTH:   state_d = S_REB_CHECK;
            S_REB_CHECK: state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            id_q        <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            resp_data_q <= resp_data_d;
        end
    end

    // op_q only changes on the edge into ISSUE, so it is also the
    // "last issued operand" in every other state.
    assign hc_data_in = op_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_id    = id_q;

`ifdef HARE_SCHED_REBIRTH_EN
    // A request landing in REBIRTH/REB_CHECK must survive the clear so a
    // second rebirth follows.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        pending_d = pending_q;
        err_d     = err_q;
        if (state_q == S_CAPTURE && op_cnt_q != 8'hFF) op_cnt_d = op_cnt_q + 8'd1;
        if (state_q == S_REBIRTH) pending_d = 1'b0;
        if (state_q == S_REB_CHECK) begin
            op_cnt_d = '0;
            if (!hc_rebirth_active) err_d = 1'b1;
        end
        if (rebirth_req) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign hc_trigger_rebirth = (state_q == S_REBIRTH);
    assign rebirth_done       = (state_q == S_REB_CHECK);
    assign rebirth_err        = err_q;
`else
    logic unused_rebirth_inputs;
    assign unused_rebirth_inputs = rebirth_req ^ hc_rebirth_active;

    assign hc_trigger_rebirth = 1'b0;
    assign rebirth_done       = 1'b0;
    assign rebirth_err        = 1'b0;
`endif

endmodule

// File: tb/tb_hare_scheduler.sv
// Self-checking bench for hare_scheduler: directed vector table, corner sequences,
// and a randomized run checked against a transaction-timeline model.
module tb_hare_scheduler;
    localparam int N      = 4;
    localparam int PERIOD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   grant;
    logic           resp_valid;
    logic           resp_ready;
    logic [31:0]    resp_data;
    logic [2:0]     resp_id;
    logic           rebirth_req;
    logic           rebirth_done;
    logic           rebirth_err;
    logic [31:0]    hc_data_in;
    logic           hc_trigger_rebirth;
    logic [31:0]    hc_data_out = '0;
    logic           hc_rebirth_active = 1'b0;
    logic           dp_ok = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hare_scheduler #(.N_REQ(N), .REBIRTH_PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .grant(grant), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .rebirth_req(rebirth_req),
        .rebirth_done(rebirth_done), .rebirth_err(rebirth_err),
        .hc_data_in(hc_data_in), .hc_trigger_rebirth(hc_trigger_rebirth),
        .hc_data_out(hc_data_out), .hc_rebirth_active(hc_rebirth_active)
    );

    function automatic logic [31:0] dp_f(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Behavioural datapath: registered result, acknowledges a rebirth strobe when healthy.
    always @(posedge clk) begin
        hc_data_out       <= dp_f(hc_data_in);
        hc_rebirth_active <= hc_trigger_rebirth & dp_ok;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1; rebirth_req = 1'b0;
        rand_data();
        nxt();
        req_valid = 4'hF;
        mid();
        check("grant_during_rst", 32'(grant), 32'd0);
        nxt();
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_hc_data_in"}, hc_data_in, 32'd0);
        check({tag, "_trigger"}, 32'(hc_trigger_rebirth), 32'd0);
        check({tag, "_done"}, 32'(rebirth_done), 32'd0);
        check({tag, "_err"}, 32'(rebirth_err), 32'd0);
    endtask

    // One full transaction: wait (bounded) for a grant, then check the
    // T+1..T+3 timeline and an optional stall of resp_ready.
    task automatic do_op(input logic [3:0] req, input int exp_id, input int stall,
                         output int waits);
        logic [31:0] opnd;
        logic [31:0] exp_d;
        bit got;
        got = 1'b0;
        waits = 0;
        for (int w = 0; w < 8; w++) begin
            req_valid = req;
            rand_data();
            mid();
            if (grant != '0) begin
                got = 1'b1;
                break;
            end
            waits++;
            nxt();
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no grant expected grant to %0d", exp_id);
            req_valid = '0;
            nxt();
            return;
        end
        opnd  = req_data[32*exp_id +: 32];
        exp_d = dp_f(opnd);
        check("grant", 32'(grant), 32'(1 << exp_id));
        nxt(); req_valid = '0; mid();
        check("hc_data_in_issue", hc_data_in, opnd);
        check("resp_valid_T1", 32'(resp_valid), 32'd0);
        nxt(); mid();
        check("resp_valid_T2", 32'(resp_valid), 32'd0);
        nxt();
        for (int s = 0; s <= stall; s++) begin
            resp_ready = (s == stall);
            req_valid  = (stall != 0) ? 4'hF : 4'h0;
            mid();
            check("resp_valid_T3", 32'(resp_valid), 32'd1);
            check("resp_id", 32'(resp_id), 32'(exp_id));
            check("resp_data", resp_data, exp_d);
            if (stall != 0) check("no_grant_in_resp", 32'(grant), 32'd0);
            nxt();
        end
        resp_ready = 1'b1;
        req_valid  = '0;
    endtask

    typedef struct {
        logic [3:0] req;
        int         id;
        int         stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          w;
        int          m_rr, m_ops, free_at, resp_at, trig_at, done_at, m_id, pick;
        bit          op_out, erv;
        logic [3:0]  eg;
        logic [31:0] m_data;
        logic [31:0] opnd;

        // Expected ids follow round-robin from rr_ptr=0 after reset.
        vecs[0] = '{4'b0001, 0, 0};
        vecs[1] = '{4'b1111, 1, 0};
        vecs[2] = '{4'b0001, 0, 0};
        vecs[3] = '{4'b1010, 1, 2};
        vecs[4] = '{4'b1010, 3, 0};
        vecs[5] = '{4'b1000, 3, 0};
        vecs[6] = '{4'b0110, 1, 0};
        vecs[7] = '{4'b1111, 2, 0};

        do_reset();
        mid();
        check_zero("reset");
        nxt();

        for (int v = 0; v < 8; v++) do_op(vecs[v].req, vecs[v].id, vecs[v].stall, w);

        // Fairness with all requesters active.
        do_reset();
        for (int k = 0; k < 8; k++) do_op(4'hF, k % N, 0, w);

        // Backpressure: 5 stalled cycles with every requester waiting.
        do_reset();
        do_op(4'b0010, 1, 5, w);

        // Reset during CAPTURE abandons the op.
        do_reset();
        req_valid = 4'b0100;
        rand_data();
        opnd = req_data[95:64];
        mid();
        check("abort_grant", 32'(grant), 32'b0100);
        nxt(); req_valid = '0; mid();
        check("abort_issue_data", hc_data_in, opnd);
        nxt(); rst = 1'b1; mid();
        nxt(); rst = 1'b0; mid();
        check_zero("abort");
        for (int c = 0; c < 5; c++) begin
            nxt(); mid();
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            check("abort_no_grant", 32'(grant), 32'd0);
        end
        nxt();

`ifdef HARE_SCHED_REBIRTH_EN
        // Periodic rebirth after PERIOD completed ops; rebirth beats waiting requests.
        do_reset();
        for (int k = 0; k < PERIOD; k++) do_op(4'hF, k % N, 0, w);
        req_valid = 4'hF;
        mid();
        check("per_idle_grant", 32'(grant), 32'd0);
        check("per_idle_trig", 32'(hc_trigger_rebirth), 32'd0);
        nxt(); mid();
        check("per_trig", 32'(hc_trigger_rebirth), 32'd1);
        check("per_trig_grant", 32'(grant), 32'd0);
        nxt(); mid();
        check("per_done", 32'(rebirth_done), 32'd1);
        check("per_done_trig", 32'(hc_trigger_rebirth), 32'd0);
        check("per_done_grant", 32'(grant), 32'd0);
        nxt();
        do_op(4'hF, PERIOD % N, 0, w);
        check("per_fifth_grant_wait", 32'(w), 32'd0);
        check("per_err", 32'(rebirth_err), 32'd0);

        // Datapath never acknowledges: error is sticky until reset.
        do_reset();
        dp_ok = 1'b0;
        rebirth_req = 1'b1;
        nxt(); rebirth_req = 1'b0;
        nxt(); mid();
        check("flt_trig", 32'(hc_trigger_rebirth), 32'd1);
        nxt(); mid();
        check("flt_done", 32'(rebirth_done), 32'd1);
        nxt(); mid();
        check("flt_err_set", 32'(rebirth_err), 32'd1);
        nxt();
        dp_ok = 1'b1;
        do_op(4'b0001, 0, 0, w);
        mid();
        check("flt_err_sticky", 32'(rebirth_err), 32'd1);
        nxt();
        do_reset();
        mid();
        check("flt_err_cleared", 32'(rebirth_err), 32'd0);
        nxt();

        // A request during REBIRTH forces a second rebirth.
        rebirth_req = 1'b1;
        nxt(); rebirth_req = 1'b0;
        nxt(); rebirth_req = 1'b1; mid();
        check("dbl_trig1", 32'(hc_trigger_rebirth), 32'd1);
        nxt(); rebirth_req = 1'b0; mid();
        check("dbl_done1", 32'(rebirth_done), 32'd1);
        nxt(); mid();
        check("dbl_idle", 32'(hc_trigger_rebirth), 32'd0);
        nxt(); mid();
        check("dbl_trig2", 32'(hc_trigger_rebirth), 32'd1);
        nxt(); mid();
        check("dbl_done2", 32'(rebirth_done), 32'd1);
        nxt(); mid();
        check("dbl_quiet", 32'(hc_trigger_rebirth | rebirth_done), 32'd0);
        check("dbl_err", 32'(rebirth_err), 32'd0);
        nxt();
`endif

        // Randomized run against a timeline model: an accepted op answers 3 cycles
        // after its grant, the scheduler is free the cycle after the handshake, and
        // an owed rebirth costs one decision cycle plus trigger and done cycles.
        do_reset();
        m_rr = 0; m_ops = 0; free_at = 0; resp_at = 0; op_out = 1'b0;
        trig_at = -1; done_at = -1; m_id = 0; m_data = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid  = 4'($urandom_range(0, 15));
            rand_data();
            resp_ready = ($urandom_range(0, 3) != 0);
            mid();
            eg = '0;
            if (!op_out && cyc >= free_at) begin
`ifdef HARE_SCHED_REBIRTH_EN
                if (m_ops == PERIOD) begin
                    trig_at = cyc + 1; done_at = cyc + 2; free_at = cyc + 3; m_ops = 0;
                end else
`endif
                if (req_valid != '0) begin
                    pick = 0;
                    for (int k = N - 1; k >= 0; k--)
                        if (req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
                    eg      = 4'(1 << pick);
                    op_out  = 1'b1;
                    resp_at = cyc + 3;
                    m_data  = dp_f(req_data[32*pick +: 32]);
                    m_id    = pick;
                    m_rr    = (pick + 1) % N;
                end
            end
            erv = op_out && (cyc >= resp_at);
            check("rnd_grant", 32'(grant), 32'(eg));
            check("rnd_resp_valid", 32'(resp_valid), 32'(erv));
            check("rnd_trigger", 32'(hc_trigger_rebirth), 32'(cyc == trig_at));
            check("rnd_done", 32'(rebirth_done), 32'(cyc == done_at));
            if (erv) begin
                check("rnd_resp_data", resp_data, m_data);
                check("rnd_resp_id", 32'(resp_id), 32'(m_id));
                if (resp_ready) begin
                    op_out  = 1'b0;
                    free_at = cyc + 1;
                    m_ops++;
                end
            end
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
